// File: rtl/vxe_mem_hub_mas_ds_gen.sv
// rtl/vxe_mem_hub_mas_ds_gen.sv - master-port downstream response router with per-client FIFOs
// Status/data words are steered by client id into per-client FIFOs, each drained by a valid/ready stage.

module vxe_mem_hub_mas_ds_gen_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          rdy_i,
  output logic [W-1:0]  data_o,
  output logic          wr_o,
  output logic [AW:0]   cnt_o
);
  localparam int D = 1 << AW;

  logic [W-1:0] mem_q [D];
  logic [AW:0]  wp_q, rp_q;
  logic [W-1:0] data_q;
  logic         wr_q;
  logic         empty, full, pop;

  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  // Refill the output register whenever it is free or being drained this cycle.
  assign pop    = !empty && (!wr_q || rdy_i);
  assign cnt_o  = wp_q - rp_q;
  assign data_o = data_q;
  assign wr_o   = wr_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      if (push_i) wp_q <= wp_q + (AW+1)'(1);
      if (pop) begin
        rp_q   <= rp_q + (AW+1)'(1);
        data_q <= mem_q[rp_q[AW-1:0]];
        wr_q   <= 1'b1;
      end else if (wr_q && rdy_i) begin
        wr_q <= 1'b0;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!nrst) !(push_i && full));
endmodule

module vxe_mem_hub_mas_ds_gen #(
  parameter int NCLIENTS = 3,
  parameter int DATA_W   = 64,
  parameter int RSS_W    = 9,
  parameter int CID_W    = 2,
  parameter int FIFO_AW  = 2
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         i_m_rss_vld,
  input  logic [RSS_W-1:0]             i_m_rss,
  output logic                         o_m_rss_rd,
  input  logic                         i_m_rsd_vld,
  input  logic [DATA_W-1:0]            i_m_rsd,
  output logic                         o_m_rsd_rd,
  input  logic [NCLIENTS-1:0]          i_cl_rss_rdy,
  output logic [NCLIENTS*RSS_W-1:0]    o_cl_rss,
  output logic [NCLIENTS-1:0]          o_cl_rss_wr,
  input  logic [NCLIENTS-1:0]          i_cl_rsd_rdy,
  output logic [NCLIENTS*DATA_W-1:0]   o_cl_rsd,
  output logic [NCLIENTS-1:0]          o_cl_rsd_wr,
  output logic [7:0]                   o_bad_cid_cnt
);
  localparam logic [FIFO_AW:0] STALL_LVL = (FIFO_AW+1)'((1 << FIFO_AW) - 1);

  typedef enum logic [1:0] {IDLE, READ, STALL} state_e;

  state_e              state_q;
  logic                rss_rd_q, rsd_rd_q;
  logic                hold_vld_q, hold_vld_d, hold_ld;
  logic [DATA_W-1:0]   hold_q, d_data;
  logic [7:0]          bad_cnt_q;
  logic [NCLIENTS-1:0] s_push, d_push, lvl_hi;
  logic [CID_W-1:0]    cid;
  logic                cid_ok, rnw, rss_acc, rsd_acc, stall;

  assign cid     = i_m_rss[RSS_W-1 -: CID_W];
  assign cid_ok  = 32'(cid) < 32'(NCLIENTS);
  assign rnw     = i_m_rss[2];
  assign rss_acc = i_m_rss_vld && rss_rd_q;
  assign rsd_acc = i_m_rsd_vld && rsd_rd_q;
  assign stall   = |lvl_hi;

  assign o_m_rss_rd    = rss_rd_q;
  assign o_m_rsd_rd    = rsd_rd_q;
  assign o_bad_cid_cnt = bad_cnt_q;

  // Data taken without a matching read status belongs to a later read and is parked in hold.
  always_comb begin
    s_push     = '0;
    d_push     = '0;
    d_data     = i_m_rsd;
    hold_ld    = 1'b0;
    hold_vld_d = hold_vld_q;
    for (int c = 0; c < NCLIENTS; c++) begin
      if (rss_acc && cid_ok && (cid == CID_W'(c))) begin
        s_push[c] = 1'b1;
        if (rnw && (hold_vld_q || rsd_acc)) d_push[c] = 1'b1;
      end
    end
    if (rss_acc && cid_ok && rnw) begin
      if (hold_vld_q) begin
        d_data     = hold_q;
        hold_vld_d = 1'b0;
      end
    end else if (rsd_acc) begin
      hold_ld    = 1'b1;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      rss_rd_q   <= 1'b0;
      rsd_rd_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      bad_cnt_q  <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      if (hold_ld) hold_q <= i_m_rsd;
      if (rss_acc && !cid_ok && (bad_cnt_q != 8'hff)) bad_cnt_q <= bad_cnt_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (i_m_rss_vld) begin
            state_q  <= READ;
            rss_rd_q <= 1'b1;
            rsd_rd_q <= 1'b1;
          end
        end
        READ: begin
          if (stall) begin
            state_q  <= STALL;
            rss_rd_q <= 1'b0;
            rsd_rd_q <= 1'b0;
          end else begin
            rss_rd_q <= 1'b1;
            rsd_rd_q <= !hold_vld_d;
          end
        end
        STALL: begin
          if (!stall) begin
            state_q  <= READ;
            rss_rd_q <= 1'b1;
            rsd_rd_q <= !hold_vld_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NCLIENTS; c++) begin : g_cl
    logic [FIFO_AW:0] s_cnt, d_cnt;

    vxe_mem_hub_mas_ds_gen_fifo #(.W(RSS_W), .AW(FIFO_AW)) u_rss_fifo (
      .clk         (clk),
      .nrst        (nrst),
      .push_i      (s_push[c]),
      .push_data_i (i_m_rss),
      .rdy_i       (i_cl_rss_rdy[c]),
      .data_o      (o_cl_rss[c*RSS_W +: RSS_W]),
      .wr_o        (o_cl_rss_wr[c]),
      .cnt_o       (s_cnt)
    );

    vxe_mem_hub_mas_ds_gen_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_rsd_fifo (
      .clk         (clk),
      .nrst        (nrst),
      .push_i      (d_push[c]),
      .push_data_i (d_data),
      .rdy_i       (i_cl_rsd_rdy[c]),
      .data_o      (o_cl_rsd[c*DATA_W +: DATA_W]),
      .wr_o        (o_cl_rsd_wr[c]),
      .cnt_o       (d_cnt)
    );

    assign lvl_hi[c] = (s_cnt >= STALL_LVL) || (d_cnt >= STALL_LVL);
  end

  a_rd_has_data: assert property (@(posedge clk) disable iff (!nrst)
    !(rss_acc && cid_ok && rnw && !hold_vld_q && !rsd_acc));
endmodule

// File: tb/tb_vxe_mem_hub_mas_ds_gen.sv
// tb/tb_vxe_mem_hub_mas_ds_gen.sv - scoreboard bench for the master-port downstream router
module tb_vxe_mem_hub_mas_ds_gen;
  localparam int NCL = 3;
  localparam int DW  = 64;
  localparam int SW  = 9;
  localparam int AW  = 2;
  localparam int D   = 1 << AW;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic i_m_rss_vld = 1'b0;
  logic [SW-1:0] i_m_rss = '0;
  logic o_m_rss_rd;
  logic i_m_rsd_vld = 1'b0;
  logic [DW-1:0] i_m_rsd = '0;
  logic o_m_rsd_rd;
  logic [NCL-1:0] i_cl_rss_rdy = '0;
  logic [NCL-1:0] i_cl_rsd_rdy = '0;
  logic [NCL*SW-1:0] o_cl_rss;
  logic [NCL-1:0] o_cl_rss_wr;
  logic [NCL*DW-1:0] o_cl_rsd;
  logic [NCL-1:0] o_cl_rsd_wr;
  logic [7:0] o_bad_cid_cnt;

  int checks = 0;
  int failures = 0;
  int n_rss_xfer = 0;

  logic [SW-1:0] m_rss_q [$];
  logic [DW-1:0] m_rsd_q [$];
  logic [SW-1:0] exp_s [NCL][$];
  logic [DW-1:0] exp_d [NCL][$];

  always #5 clk = ~clk;

  vxe_mem_hub_mas_ds_gen #(
    .NCLIENTS(NCL), .DATA_W(DW), .RSS_W(SW), .CID_W(2), .FIFO_AW(AW)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_m_rss_vld  (i_m_rss_vld),
    .i_m_rss      (i_m_rss),
    .o_m_rss_rd   (o_m_rss_rd),
    .i_m_rsd_vld  (i_m_rsd_vld),
    .i_m_rsd      (i_m_rsd),
    .o_m_rsd_rd   (o_m_rsd_rd),
    .i_cl_rss_rdy (i_cl_rss_rdy),
    .o_cl_rss     (o_cl_rss),
    .o_cl_rss_wr  (o_cl_rss_wr),
    .i_cl_rsd_rdy (i_cl_rsd_rdy),
    .o_cl_rsd     (o_cl_rsd),
    .o_cl_rsd_wr  (o_cl_rsd_wr),
    .o_bad_cid_cnt(o_bad_cid_cnt)
  );

  // Master model: independent status and data streams, popped on vld & rd at each edge.
  always begin : drv
    logic xs, xd;
    @(posedge clk);
    xs = i_m_rss_vld && o_m_rss_rd;
    xd = i_m_rsd_vld && o_m_rsd_rd;
    #1;
    if (xs) begin
      void'(m_rss_q.pop_front());
      n_rss_xfer++;
    end
    if (xd) void'(m_rsd_q.pop_front());
    i_m_rss_vld = (m_rss_q.size() != 0);
    i_m_rss     = (m_rss_q.size() != 0) ? m_rss_q[0] : '0;
    i_m_rsd_vld = (m_rsd_q.size() != 0);
    i_m_rsd     = (m_rsd_q.size() != 0) ? m_rsd_q[0] : '0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [SW-1:0] mk(input int cid, input int tag, input bit rnw);
    logic [1:0] c2;
    logic [3:0] t4;
    c2 = 2'(cid);
    t4 = 4'(tag);
    return {c2, t4, rnw, t4[1:0]};
  endfunction

  task automatic send(input int cid, input int tag, input bit rnw, input bit has_data,
                      input logic [DW-1:0] data);
    logic [SW-1:0] s;
    s = mk(cid, tag, rnw);
    m_rss_q.push_back(s);
    if (has_data) m_rsd_q.push_back(data);
    if (cid < NCL) begin
      exp_s[cid].push_back(s);
      if (has_data && rnw) exp_d[cid].push_back(data);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h required=%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [SW-1:0] es;
    logic [DW-1:0] ed;
    for (int c = 0; c < NCL; c++) begin
      if (o_cl_rss_wr[c]) begin
        checks++;
        assert (exp_s[c].size() != 0) else begin
          failures++;
          $error("FAIL unexp_rss_c%0d got=%0h required=none", c, o_cl_rss[c*SW +: SW]);
        end
        if (i_cl_rss_rdy[c] && exp_s[c].size() != 0) begin
          es = exp_s[c].pop_front();
          chk($sformatf("rss_c%0d", c), 64'(o_cl_rss[c*SW +: SW]), 64'(es));
        end
      end
      if (o_cl_rsd_wr[c]) begin
        checks++;
        assert (exp_d[c].size() != 0) else begin
          failures++;
          $error("FAIL unexp_rsd_c%0d got=%0h required=none", c, o_cl_rsd[c*DW +: DW]);
        end
        if (i_cl_rsd_rdy[c] && exp_d[c].size() != 0) begin
          ed = exp_d[c].pop_front();
          chk($sformatf("rsd_c%0d", c), o_cl_rsd[c*DW +: DW], ed);
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
  endtask

  function automatic bit idle();
    if (m_rss_q.size() != 0 || m_rsd_q.size() != 0) return 1'b0;
    for (int c = 0; c < NCL; c++)
      if (exp_s[c].size() != 0 || exp_d[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (n < bound && !idle()) begin
      cyc();
      n++;
    end
    checks++;
    assert (idle()) else begin
      failures++;
      $error("FAIL %s_drain got=pending required=empty", tag);
    end
    cyc();
    cyc();
    chk({tag, "_wr_clear"}, 64'({o_cl_rss_wr, o_cl_rsd_wr}), 64'(0));
  endtask

  initial begin
    int base, n;
    nrst = 1'b0;
    i_cl_rss_rdy = '1;
    i_cl_rsd_rdy = '1;

    // Reset with master inputs active
    send(0, 1, 1'b1, 1'b1, 64'h11);
    repeat (3) cyc();
    chk("rst_rss_rd", 64'(o_m_rss_rd), 64'(0));
    chk("rst_rsd_rd", 64'(o_m_rsd_rd), 64'(0));
    chk("rst_cl_wr", 64'({o_cl_rss_wr, o_cl_rsd_wr}), 64'(0));
    chk("rst_cl_data", 64'({|o_cl_rss, |o_cl_rsd}), 64'(0));
    chk("rst_bad_cnt", 64'(o_bad_cid_cnt), 64'(0));
    nrst = 1'b1;
    cyc();
    chk("rd_edge1", 64'({o_m_rss_rd, o_m_rsd_rd}), 64'(3));
    chk("no_xfer_edge1", 64'(n_rss_xfer), 64'(0));
    cyc();
    chk("xfer_edge2", 64'(n_rss_xfer), 64'(1));
    chk("lat_push", 64'(o_cl_rss_wr[0]), 64'(0));
    cyc();
    chk("lat_rss_load", 64'(o_cl_rss_wr[0]), 64'(1));
    chk("lat_rsd_load", 64'(o_cl_rsd_wr[0]), 64'(1));
    drain("rst", 20);

    // Read stream to client 1, full throughput
    for (int i = 1; i <= 8; i++) send(1, i, 1'b1, 1'b1, 64'(i));
    repeat (3) cyc();
    for (int i = 0; i < 8; i++) begin
      chk("tp_rss_wr1", 64'(o_cl_rss_wr[1]), 64'(1));
      chk("tp_rsd_wr1", 64'(o_cl_rsd_wr[1]), 64'(1));
      cyc();
    end
    chk("tp_end", 64'({o_cl_rss_wr[1], o_cl_rsd_wr[1]}), 64'(0));
    drain("stream", 20);

    // Write then read: read data arrives alongside the write status
    send(0, 5, 1'b0, 1'b0, '0);
    send(2, 6, 1'b1, 1'b1, 64'hAA);
    cyc();
    cyc();
    chk("hold_rsd_rd", 64'(o_m_rsd_rd), 64'(0));
    cyc();
    chk("rel_rsd_rd", 64'(o_m_rsd_rd), 64'(1));
    drain("wr_rd", 20);

    // Backpressure on client 0
    i_cl_rss_rdy[0] = 1'b0;
    i_cl_rsd_rdy[0] = 1'b0;
    base = n_rss_xfer;
    for (int i = 0; i < 10; i++) send(0, i, 1'b1, 1'b1, 64'h100 + 64'(i));
    n = 0;
    while (o_m_rss_rd && n < 50) begin
      cyc();
      n++;
    end
    chk("bp_rd_drop", 64'(o_m_rss_rd), 64'(0));
    repeat (5) cyc();
    chk("bp_accepted", 64'(n_rss_xfer - base), 64'(D + 1));
    chk("bp_rsd_rd", 64'(o_m_rsd_rd), 64'(0));
    chk("bp_out_rss", 64'(o_cl_rss[SW-1:0]), 64'(mk(0, 0, 1'b1)));
    chk("bp_out_rsd", o_cl_rsd[DW-1:0], 64'h100);
    i_cl_rss_rdy[0] = 1'b1;
    i_cl_rsd_rdy[0] = 1'b1;
    drain("bp", 80);
    chk("bp_resume", 64'(o_m_rss_rd), 64'(1));

    // Unknown client id 3
    for (int i = 0; i < 200; i++) send(3, i, 1'(i % 2), 1'b0, '0);
    drain("bad200", 400);
    chk("bad_cnt_200", 64'(o_bad_cid_cnt), 64'(200));
    for (int i = 0; i < 100; i++) send(3, i, 1'(i % 2), 1'b0, '0);
    drain("bad300", 200);
    chk("bad_cnt_sat", 64'(o_bad_cid_cnt), 64'(255));

    // Wrap-around with random ready and interleaved writes
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < NCL; c++) begin
        if (i % 5 == 4) send((c + 1) % NCL, i, 1'b0, 1'b0, '0);
        send(c, i, 1'b1, 1'b1, {8'(c), 8'(i), 48'($urandom)});
      end
    end
    n = 0;
    while (!idle() && n < 3000) begin
      i_cl_rss_rdy = NCL'($urandom);
      i_cl_rsd_rdy = NCL'($urandom);
      cyc();
      n++;
    end
    i_cl_rss_rdy = '1;
    i_cl_rsd_rdy = '1;
    drain("wrap", 100);
    chk("wrap_rd", 64'({o_m_rss_rd, o_m_rsd_rd}), 64'(3));
    chk("wrap_bad_cnt", 64'(o_bad_cid_cnt), 64'(255));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vxe_mem_hub_mas_ds_gen.md
# vxe_mem_hub_mas_ds_gen

Parametrised master-port downstream response router for the VxE memory hub. It accepts response status and data words from the master port and steers each to one of NCLIENTS client channels by the client-id field of the transaction id. Each client channel has independent status and data FIFOs with a valid/ready output stage. It keeps status/data ordering across interleaved read and write responses and counts responses with an unknown client id.

## Interface
Parameters:
- NCLIENTS, 3: number of client channels (1..4); client id c selects channel c.
- DATA_W, 64: response data width.
- RSS_W, 9: response status width; format {txnid[RSS_W-4:0], rnw, err[1:0]}, rnw = bit 2.
- CID_W, 2: client-id width; client id = i_m_rss[RSS_W-1 -: CID_W].
- FIFO_AW, 2: log2 FIFO depth; depth D = 2^FIFO_AW, D >= 4.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_m_rss_vld  in  1  master status word available
- i_m_rss  in  RSS_W  master status word
- o_m_rss_rd  out  1  status read enable; transfer = vld & rd
- i_m_rsd_vld  in  1  master data word available
- i_m_rsd  in  DATA_W  master data word
- o_m_rsd_rd  out  1  data read enable; transfer = vld & rd
- i_cl_rss_rdy  in  NCLIENTS  per-client status ready
- o_cl_rss  out  NCLIENTS*RSS_W  per-client status, client c at [c*RSS_W +: RSS_W]
- o_cl_rss_wr  out  NCLIENTS  per-client status valid
- i_cl_rsd_rdy  in  NCLIENTS  per-client data ready
- o_cl_rsd  out  NCLIENTS*DATA_W  per-client data, client c at [c*DATA_W +: DATA_W]
- o_cl_rsd_wr  out  NCLIENTS  per-client data valid
- o_bad_cid_cnt  out  8  count of responses with client id >= NCLIENTS, saturates at 255

## Operation
- Rx FSM states: IDLE, READ, STALL.
  - IDLE -> READ when i_m_rss_vld; set both rd to 1.
  - READ -> STALL when stall=1; both rd to 0.
  - STALL -> READ when stall=0; rss_rd=1, rsd_rd=~hold_vld.
- stall = any client status or data FIFO with count >= D-1.
- Accepted status word (READ, i_m_rss_vld & o_m_rss_rd), client c valid:
  - Status is pushed to status FIFO c.
  - rnw=1, hold_vld=1: hold register is pushed to data FIFO c; hold_vld cleared; rsd_rd=1.
  - rnw=1, hold_vld=0, i_m_rsd_vld=1: i_m_rsd is pushed to data FIFO c.
  - rnw=0, hold_vld=0, i_m_rsd_vld=1: i_m_rsd is captured in the hold register; hold_vld=1; rsd_rd=0. This data belongs to a later read response.
  - rnw=1 with no data available is a protocol error. Simulation-only $display; status is still pushed.
- Client id >= NCLIENTS: nothing is pushed and o_bad_cid_cnt increments (saturating). Data handling is the same as for rnw=0.
- Output stage, per FIFO: a 1-entry register with wr flag.
  - Load when wr=0 and FIFO non-empty, or when wr&rdy and FIFO non-empty.
  - Clear wr when wr&rdy and FIFO empty.
  - The output holds its value while wr & ~rdy.
- FIFO pointers are FIFO_AW+1 bits; the MSB is the wrap bit. empty = pointers equal; full = low bits equal and MSBs differ.

## Timing
- Reset values:
  - o_m_rss_rd=0, o_m_rsd_rd=0.
  - all o_cl_*_wr=0, o_cl_rss=0, o_cl_rsd=0, o_bad_cid_cnt=0.
  - FSM=IDLE, hold_vld=0, all pointers 0.
- Reset mid-operation discards FIFO contents and the hold register immediately.
- o_m_*_rd are registered, so the first transfer occurs one cycle after IDLE sees i_m_rss_vld.
- Latency, master accept edge to o_cl_*_wr=1 with an empty FIFO: 2 clk edges (push, then load).
- Throughput: 1 status/cycle into the hub; 1 word/cycle per client output when rdy is held high.
- Stall threshold D-1 covers the 1-cycle registered-rd latency: at most one more push after threshold. A FIFO never overflows; a push into a full FIFO is a design error (assert in sim).
- Simultaneous push and pop on the same FIFO in one cycle: count is unchanged.
- The output stage pops in the same cycle it drains.

## Test plan
- Reset with all inputs active: all outputs 0 during nrst=0. After release with rss_vld=1, rd goes high on the 1st edge and the first transfer is on the 2nd.
- Read stream to client 1, rdy=1: 8 read responses with data 0x1..0x8. Client 1 receives status and data in order, 1/cycle after a 2-cycle latency. Other clients' wr stays 0.
- Write-then-read ordering: write status W (client 0) arrives with read data 0xAA present. 0xAA is held and rsd_rd drops. The next read status R (client 2) delivers 0xAA to client 2 only, and rsd_rd returns to 1.
- Backpressure: client 0 rdy=0 with 10 reads sent. rd drops once the count reaches D-1. No overflow; at most D words are queued plus 1 in the output register. rdy=1 releases all words in order and resumes reads.
- Bad client id 3 with NCLIENTS=3: 300 such responses. Nothing is delivered and o_bad_cid_cnt saturates at 255.
- Wrap-around: with D=4 and random rdy, push 20 words per client. Sequences are intact and empty/full are flagged correctly across MSB toggles.
